counter_run_ctrl: RTL and testbench
===================================

// Module: counter_run_ctrl
// PURPOSE
//   Command-driven sequencer for the 8-bit up-counter datapath on the TT user tile.
//   Accepts CLEAR / LOAD / RUN / STOP commands over a valid/ready interface.
//   Gates counter steps through a programmable prescaler.
//   Signals completion of bounded runs and rejects illegal commands.
//   Sits between ui_in/uio_in decode logic and the uo_out counter display path.
// PARAMETERS
//   WIDTH     8  counter, load-value and run-length width
//   PRE_W     4  prescaler divisor width
// PORTS
//   clk           in   1        single clock; all state on posedge clk
//   rst           in   1        asynchronous, active-high reset
//   cmd_valid     in   1        command present
//   cmd_ready     out  1        command accepted on an edge where cmd_valid & cmd_ready
//   cmd_op        in   2        00 CLEAR, 01 LOAD, 10 RUN, 11 STOP
//   cmd_arg       in   WIDTH    LOAD: value; RUN: step count N (0 = free-run)
//   prescale_div  in   PRE_W    D: one step every D+1 cycles; latched at RUN accept
//   count         out  WIDTH    counter value
//   busy          out  1        high while in RUN
//   done          out  1        1-cycle pulse when a bounded RUN completes
//   err           out  1        1-cycle pulse when a command is rejected
// BEHAVIOUR
//   Reset (async, any state):
//     state=IDLE; count=0; done=err=0; prescaler and remaining cleared; busy=0; cmd_ready=1.
//   States IDLE, RUN, DONE:
//     cmd_ready = (state != DONE)   [combinational from state only]
//     busy      = (state == RUN)
//     done      = (state == DONE)
//   IDLE, accepted command:
//     CLEAR: count<=0.
//     LOAD:  count<=cmd_arg.
//     RUN:   remaining<=cmd_arg; pre<=0; div<=prescale_div; ->RUN.
//     STOP:  no-op, no err.
//     New count value is visible the cycle after the accept edge.
//   RUN, each edge:
//     If pre==div: pre<=0, count<=count+1 (mod 2^WIDTH, 255->0 silently).
//       If remaining!=0, remaining<=remaining-1.
//       If remaining==1, ->DONE on that same edge.
//     Otherwise: pre<=pre+1.
//   RUN, accepted STOP:
//     ->IDLE; a step due on that edge is suppressed; no done.
//   RUN, accepted CLEAR/LOAD/RUN:
//     Command consumed and ignored; err=1 for the next cycle; run continues unaffected.
//   DONE: lasts exactly 1 cycle, ->IDLE. cmd_ready=0, so no command can be lost.
//   Latency: RUN(N,D) accepted at edge 0 -> steps at edges k*(D+1), k=1..N.
//     done is high during the cycle after edge N*(D+1).
//   Free-run (N=0): steps indefinitely, wraps, exits only via STOP or rst.
//   D=0: one step per cycle. Changing prescale_div mid-run has no effect.
//   done and err are registered and never high together.
// STRUCTURE
//   Shared package counter_ctrl_pkg holds:
//     op codes OP_CLEAR/OP_LOAD/OP_RUN/OP_STOP
//     state encoding ST_IDLE/ST_RUN/ST_DONE
//     ST_W state width
//   Sub-module counter_prescaler (PRE_W):
//     inputs clk, rst, restart, div; output tick.
//     tick is high on the cycle where pre==div.
//   Top level holds the FSM, remaining-step counter and count register.
// TESTING
//   Reset: rst pulse mid-RUN(N=10,D=3) -> next cycle count=0, busy=0, no done; cmd_ready=1.
//   LOAD 0xFE, then RUN N=3 D=0 -> count 0xFF, 0x00, 0x01 on consecutive cycles;
//     done high exactly 1 cycle after the 0x01 step.
//   CLEAR, RUN N=2 D=2 -> count steps at edges 3 and 6 after accept; done at cycle 7;
//     cmd_ready=0 only in that cycle.
//   RUN N=0 D=0 from 0x00, STOP on cycle 5 -> count=0x04, busy drops, no done.
//   LOAD 0x55 issued during RUN -> err pulses once; count unaffected; run completes normally.
//   STOP in IDLE and back-to-back CLEAR/LOAD -> no err; count tracks each command next cycle.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter run controller: command op codes and FSM states.
package counter_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_RUN   = 2'b10,
    OP_STOP  = 2'b11
  } op_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Step-rate divider: tick fires once every div+1 cycles; divisor captured on restart.
module counter_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] pre_q, div_q;

  assign tick = (pre_q == div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      div_q <= '0;
    end else if (restart) begin
      pre_q <= '0;
      div_q <= div;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// Command sequencer for the up-counter: CLEAR/LOAD/RUN/STOP over valid/ready,
// prescaled stepping, done pulse on bounded-run completion, err pulse on rejects.
module counter_run_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [PRE_W-1:0] prescale_div,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             err_defer_q, err_defer_d;
  logic             accept, restart, reject, tick;
  op_e              op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q != ST_DONE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign count     = count_q;

  counter_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .div    (prescale_div),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    restart = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_CLEAR: count_d = '0;
            OP_LOAD:  count_d = cmd_arg;
            OP_RUN: begin
              rem_d   = cmd_arg;
              restart = 1'b1;
              state_d = ST_RUN;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // STOP wins over a step due on the same edge.
        if (accept && op == OP_STOP) begin
          state_d = ST_IDLE;
        end else begin
          reject = accept;
          if (tick) begin
            count_d = count_q + 1'b1;
            if (rem_q != '0) rem_d = rem_q - 1'b1;
            if (rem_q == WIDTH'(1)) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A reject landing on the completing edge is reported one cycle late so
    // that done and err never overlap; DONE holds cmd_ready low, so no clash follows.
    err_d       = (reject & (state_d != ST_DONE)) | err_defer_q;
    err_defer_d = reject & (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      err_defer_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      err_defer_q <= err_defer_d;
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl with hand-computed expectations.
module tb_counter_run_ctrl;

  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_arg = '0;
  logic [PRE_W-1:0] prescale_div = '0;
  logic [WIDTH-1:0] count;
  logic             busy, done, err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_run_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .prescale_div(prescale_div),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one command for a single edge; returns #1 after the accept edge.
  task automatic cmd(input logic [1:0] op, input logic [WIDTH-1:0] arg, input logic [PRE_W-1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; prescale_div = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #12; rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Reset mid-run (N=10, D=3): one step lands at edge 4.
    cmd(2'b10, 8'd10, 4'd3);
    chk("run_busy", busy, 1);
    step(5);
    chk("mid_count", count, 1);
    #2 rst = 1'b1; #1;
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    step(1);
    rst = 1'b0;
    chk("rst2_count", count, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_done", done, 0);
    chk("rst2_ready", cmd_ready, 1);

    // LOAD 0xFE then RUN N=3 D=0: wrap through 0xFF, 0x00, 0x01.
    cmd(2'b01, 8'hFE, 4'd0);
    chk("load_fe", count, 8'hFE);
    cmd(2'b10, 8'd3, 4'd0);
    chk("w_e0", count, 8'hFE);
    step(1); chk("w_e1", count, 8'hFF); chk("w_e1_done", done, 0);
    step(1); chk("w_e2", count, 8'h00); chk("w_e2_done", done, 0);
    step(1); chk("w_e3", count, 8'h01); chk("w_e3_done", done, 1);
    chk("w_e3_busy", busy, 0);
    step(1); chk("w_e4_done", done, 0); chk("w_e4_ready", cmd_ready, 1);

    // CLEAR, RUN N=2 D=2: steps at edges 3 and 6; divisor change mid-run ignored.
    cmd(2'b00, 8'd0, 4'd0);
    chk("clr", count, 0);
    cmd(2'b10, 8'd2, 4'd2);
    prescale_div = 4'd0;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      chk($sformatf("p_cnt_e%0d", e), count, (e >= 6) ? 2 : (e >= 3) ? 1 : 0);
      chk($sformatf("p_rdy_e%0d", e), cmd_ready, (e == 6) ? 0 : 1);
      chk($sformatf("p_done_e%0d", e), done, (e == 6) ? 1 : 0);
    end

    // Free-run N=0 D=0, STOP accepted at edge 5 suppresses that step.
    cmd(2'b00, 8'd0, 4'd0);
    cmd(2'b10, 8'd0, 4'd0);
    step(4);
    chk("fr_e4", count, 4);
    cmd(2'b11, 8'd0, 4'd0);
    chk("stop_count", count, 4);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    step(1);
    chk("stop_done2", done, 0);
    chk("stop_count2", count, 4);

    // Illegal LOAD during RUN N=4 D=1: err once, count untouched, run completes.
    cmd(2'b00, 8'd0, 4'd0);
    cmd(2'b10, 8'd4, 4'd1);
    cmd(2'b01, 8'h55, 4'd0);
    chk("ill_err", err, 1);
    chk("ill_count", count, 0);
    chk("ill_busy", busy, 1);
    step(1);
    chk("ill_err2", err, 0);
    chk("ill_count2", count, 1);
    step(5);
    chk("ill_cnt7", count, 3);
    chk("ill_done7", done, 0);
    step(1);
    chk("ill_cnt8", count, 4);
    chk("ill_done8", done, 1);
    chk("ill_err8", err, 0);

    // STOP in IDLE and back-to-back CLEAR/LOAD.
    step(1);
    cmd(2'b11, 8'd0, 4'd0);
    chk("istop_err", err, 0);
    chk("istop_count", count, 4);
    cmd(2'b00, 8'd0, 4'd0);
    chk("bb_clr", count, 0);
    chk("bb_clr_err", err, 0);
    cmd(2'b01, 8'hA5, 4'd0);
    chk("bb_ld1", count, 8'hA5);
    cmd(2'b01, 8'h3C, 4'd0);
    chk("bb_ld2", count, 8'h3C);
    chk("bb_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
